// File: rtl/seven_seg_pkg.sv
// Shared constants for seven-segment loopback capture and checking.
// Segment codes are active-high {a,b,c,d,e,f,g,dp}.
package seven_seg_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [7:0] SEG_0       = 8'hFC;
  localparam logic [7:0] SEG_1       = 8'h60;
  localparam logic [7:0] SEG_2       = 8'hDA;
  localparam logic [7:0] SEG_3       = 8'hF2;
  localparam logic [7:0] SEG_4       = 8'h66;
  localparam logic [7:0] SEG_5       = 8'hB6;
  localparam logic [7:0] SEG_6       = 8'hBE;
  localparam logic [7:0] SEG_7       = 8'hE0;
  localparam logic [7:0] SEG_8       = 8'hFE;
  localparam logic [7:0] SEG_9       = 8'hF6;
  localparam logic [7:0] SEG_BLANK   = 8'h00;
  localparam logic [7:0] SEG_DP_MASK = 8'hFE;

  localparam logic [3:0] NIB_BLANK = 4'hF;
  localparam logic [3:0] NIB_ERR   = 4'hE;

  typedef enum logic {
    WAIT_STABLE = 1'b0,
    HOLD        = 1'b1
  } cap_state_e;

  // True when more than one select bit is set.
  function automatic logic multi_hot(input logic [7:0] v);
    return (v & (v - 8'd1)) != 8'd0;
  endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational segment-pattern to nibble decoder; the dp bit is ignored.
// Blank maps to NIB_BLANK, unknown patterns to NIB_ERR with valid low.
module seven_seg_decoder
  import seven_seg_pkg::*;
(
  input  logic [7:0] seg_data,
  output logic [3:0] nibble,
  output logic       valid
);

  logic [7:0] seg_masked;

  assign seg_masked = seg_data & SEG_DP_MASK;

  always_comb begin
    valid  = 1'b1;
    nibble = NIB_ERR;
    case (seg_masked)
      SEG_0:     nibble = 4'h0;
      SEG_1:     nibble = 4'h1;
      SEG_2:     nibble = 4'h2;
      SEG_3:     nibble = 4'h3;
      SEG_4:     nibble = 4'h4;
      SEG_5:     nibble = 4'h5;
      SEG_6:     nibble = 4'h6;
      SEG_7:     nibble = 4'h7;
      SEG_8:     nibble = 4'h8;
      SEG_9:     nibble = 4'h9;
      SEG_BLANK: nibble = NIB_BLANK;
      default: begin
        nibble = NIB_ERR;
        valid  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seven_seg_capture.sv
// Display readback: filters the scanned digit/segment buses, decodes each
// stable sample and hands complete 8-digit frames out on valid/ready.
module seven_seg_capture
  import seven_seg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic [7:0]  digit,
  input  logic [7:0]  seg_data,
  output logic [31:0] frame_data,
  output logic        frame_valid,
  input  logic        frame_ready,
  output logic        seg_error,
  output logic        sel_error,
  output logic        overrun
);

  localparam logic [CNT_W-1:0] STABLE_C  = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] STABLE_M1 = CNT_W'(STABLE_CYCLES - 1);

  logic [15:0]      sample;
  logic [15:0]      prev_q;
  logic             same;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  cap_state_e       state_q, state_d;
  logic             stable_hit;
  logic             accept;

  logic [3:0]       nib;
  logic             nib_valid;
  logic             sel_multi;
  logic [7:0]       wr_en;
  logic [7:0]       seen_set;

  logic [7:0]       seen_q, seen_d;
  logic [31:0]      shadow_q, shadow_d;
  logic [31:0]      frame_data_q, frame_data_d;
  logic             frame_valid_q, frame_valid_d;
  logic             seg_error_q, seg_error_d;
  logic             sel_error_q, sel_error_d;
  logic             overrun_q, overrun_d;

  assign sample     = {digit, seg_data};
  assign same       = (sample == prev_q);
  assign stable_hit = same && (cnt_q == STABLE_M1);

  // Dwell counter saturates so a held pattern cannot fire a second time.
  always_comb begin
    cnt_d = '0;
    if (same) begin
      cnt_d = (cnt_q == STABLE_C) ? cnt_q : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= WAIT_STABLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_STABLE: if (stable_hit) state_d = HOLD;
      HOLD:        if (!same)      state_d = WAIT_STABLE;
      default:                     state_d = WAIT_STABLE;
    endcase
  end

  always_comb begin
    accept = 1'b0;
    if (state_q == WAIT_STABLE) begin
      accept = stable_hit;
    end
  end

  seven_seg_decoder u_decoder (
    .seg_data (seg_data),
    .nibble   (nib),
    .valid    (nib_valid)
  );

  assign sel_multi = multi_hot(digit);

  // Position i is selected by digit bit 7-i and lands in frame nibble i.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_pos
      assign wr_en[gi] = accept && !sel_multi && digit[NUM_DIGITS-1-gi];
      assign shadow_d[31-4*gi -: 4] = wr_en[gi] ? nib : shadow_q[31-4*gi -: 4];
    end
  endgenerate

  assign seen_set = seen_q | wr_en;

  always_comb begin
    seen_d        = seen_set;
    frame_data_d  = frame_data_q;
    frame_valid_d = frame_valid_q && !frame_ready;
    overrun_d     = overrun_q;
    seg_error_d   = (|wr_en) && !nib_valid;
    sel_error_d   = accept && sel_multi;
    if (seen_set == 8'hFF) begin
      seen_d = '0;
      if (!frame_valid_q || frame_ready) begin
        frame_data_d  = shadow_d;
        frame_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      prev_q        <= '0;
      cnt_q         <= '0;
      seen_q        <= '0;
      shadow_q      <= '1;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      seg_error_q   <= 1'b0;
      sel_error_q   <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      prev_q        <= sample;
      cnt_q         <= cnt_d;
      seen_q        <= seen_d;
      shadow_q      <= shadow_d;
      frame_data_q  <= frame_data_d;
      frame_valid_q <= frame_valid_d;
      seg_error_q   <= seg_error_d;
      sel_error_q   <= sel_error_d;
      overrun_q     <= overrun_d;
    end
  end

  assign frame_data  = frame_data_q;
  assign frame_valid = frame_valid_q;
  assign seg_error   = seg_error_q;
  assign sel_error   = sel_error_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed bench for seven_seg_capture: scans the display buses and checks
// frames, error pulses, overrun and reset behaviour against hand values.
module tb_seven_seg_capture;

  logic        clk = 1'b0;
  logic        rstb;
  logic [7:0]  digit;
  logic [7:0]  seg_data;
  logic [31:0] frame_data;
  logic        frame_valid;
  logic        frame_ready;
  logic        seg_error;
  logic        sel_error;
  logic        overrun;

  int total = 0;
  int bad   = 0;
  int seg_cnt = 0;
  int sel_cnt = 0;
  int rise_cnt = 0;
  logic fv_prev = 1'b0;

  int seg_base, sel_base, rise_base;

  seven_seg_capture #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
    .clk         (clk),
    .rstb        (rstb),
    .digit       (digit),
    .seg_data    (seg_data),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .seg_error   (seg_error),
    .sel_error   (sel_error),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  // Event counters sampled on the inactive edge.
  always @(negedge clk) begin
    if (seg_error) seg_cnt++;
    if (sel_error) sel_cnt++;
    if (frame_valid && !fv_prev) rise_cnt++;
    fv_prev = frame_valid;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [7:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 8'hFC;
      4'h1: return 8'h60;
      4'h2: return 8'hDA;
      4'h3: return 8'hF2;
      4'h4: return 8'h66;
      4'h5: return 8'hB6;
      4'h6: return 8'hBE;
      4'h7: return 8'hE0;
      4'h8: return 8'hFE;
      4'h9: return 8'hF6;
      default: return 8'h00;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic [7:0] d, input logic [7:0] s, input int n);
    digit    = d;
    seg_data = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan(input logic [31:0] val, input int n);
    for (int p = 0; p < 8; p++) begin
      hold(8'h80 >> p, seg_of(val[31-4*p -: 4]), n);
    end
  endtask

  task automatic consume();
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
  endtask

  task automatic mark();
    seg_base  = seg_cnt;
    sel_base  = sel_cnt;
    rise_base = rise_cnt;
  endtask

  initial begin
    rstb        = 1'b0;
    digit       = 8'h00;
    seg_data    = 8'h00;
    frame_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_frame_data", frame_data, 32'h0);
    chk("reset_frame_valid", {31'd0, frame_valid}, 32'd0);
    chk("reset_errors", {30'd0, seg_error, sel_error}, 32'd0);
    chk("reset_overrun", {31'd0, overrun}, 32'd0);
    rstb = 1'b1;
    @(negedge clk);

    // Basic scan, frame held until consumed
    mark();
    scan(32'h12345678, 10);
    hold(8'h00, 8'h00, 5);
    chk("scan1_valid", {31'd0, frame_valid}, 32'd1);
    chk("scan1_data", frame_data, 32'h12345678);
    chk("scan1_frames", rise_cnt - rise_base, 32'd1);
    chk("scan1_errs", (seg_cnt - seg_base) + (sel_cnt - sel_base), 32'd0);
    hold(8'h00, 8'h00, 6);
    chk("scan1_hold_valid", {31'd0, frame_valid}, 32'd1);
    consume();
    chk("scan1_consumed", {31'd0, frame_valid}, 32'd0);

    // Too-short holds capture nothing
    mark();
    scan(32'h13572468, 3);
    hold(8'h00, 8'h00, 3);
    chk("short_valid", {31'd0, frame_valid}, 32'd0);
    chk("short_frames", rise_cnt - rise_base, 32'd0);

    // One-cycle glitch inside each 10-cycle hold
    mark();
    for (int p = 0; p < 8; p++) begin
      hold(8'h80 >> p, seg_of(4'(8 - p)), 4);
      hold(8'h80 >> p, 8'h01, 1);
      hold(8'h80 >> p, seg_of(4'(8 - p)), 5);
    end
    hold(8'h00, 8'h00, 5);
    chk("glitch_data", frame_data, 32'h87654321);
    chk("glitch_frames", rise_cnt - rise_base, 32'd1);
    chk("glitch_errs", (seg_cnt - seg_base) + (sel_cnt - sel_base), 32'd0);
    consume();

    // Invalid pattern and blank
    mark();
    for (int p = 0; p < 8; p++) begin
      if (p == 2)      hold(8'h80 >> p, 8'h0F, 10);
      else if (p == 5) hold(8'h80 >> p, 8'h00, 10);
      else             hold(8'h80 >> p, 8'hFC, 10);
    end
    hold(8'h00, 8'h00, 5);
    chk("segerr_pulses", seg_cnt - seg_base, 32'd1);
    chk("segerr_data", frame_data, 32'h00E00F00);
    chk("segerr_valid", {31'd0, frame_valid}, 32'd1);
    consume();

    // Multi-hot select and display-off
    mark();
    hold(8'h18, 8'hFC, 10);
    chk("selerr_pulse", sel_cnt - sel_base, 32'd1);
    hold(8'h00, 8'hFC, 10);
    chk("digit0_no_sel", sel_cnt - sel_base, 32'd1);
    chk("digit0_no_seg", seg_cnt - seg_base, 32'd0);
    chk("digit0_no_frame", {31'd0, frame_valid}, 32'd0);

    // Backpressure and overrun
    mark();
    chk("pre_overrun", {31'd0, overrun}, 32'd0);
    scan(32'h12345678, 10);
    chk("bp_first_data", frame_data, 32'h12345678);
    scan(32'h98765432, 10);
    chk("bp_overrun", {31'd0, overrun}, 32'd1);
    chk("bp_retained", frame_data, 32'h12345678);
    chk("bp_valid", {31'd0, frame_valid}, 32'd1);
    for (int p = 0; p < 7; p++) begin
      hold(8'h80 >> p, seg_of(4'(p)), 10);
    end
    digit    = 8'h01;
    seg_data = seg_of(4'h7);
    repeat (4) @(negedge clk);
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    chk("same_cycle_valid", {31'd0, frame_valid}, 32'd1);
    chk("same_cycle_data", frame_data, 32'h01234567);
    repeat (5) @(negedge clk);
    chk("bp_frames", rise_cnt - rise_base, 32'd1);
    chk("overrun_sticky", {31'd0, overrun}, 32'd1);
    consume();
    chk("bp_consumed", {31'd0, frame_valid}, 32'd0);

    // Reset in the middle of a partial frame
    for (int p = 0; p < 5; p++) begin
      hold(8'h80 >> p, seg_of(4'(9 - p)), 10);
    end
    rstb = 1'b0;
    #1;
    chk("rst_valid", {31'd0, frame_valid}, 32'd0);
    chk("rst_data", frame_data, 32'h0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    chk("rst_errors", {30'd0, seg_error, sel_error}, 32'd0);
    @(negedge clk);
    rstb = 1'b1;
    mark();
    scan(32'h24681357, 10);
    hold(8'h00, 8'h00, 5);
    chk("post_rst_frames", rise_cnt - rise_base, 32'd1);
    chk("post_rst_data", frame_data, 32'h24681357);
    chk("post_rst_overrun", {31'd0, overrun}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
